seq_mul_n: RTL and testbench



---
 rtl/seq_mul_pkg.sv | 24 ++
 rtl/add_n.sv | 23 ++
 rtl/seq_mul_n.sv | 119 +++++++++++
 tb/tb_seq_mul_n.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_mul_pkg.sv
// Shared types and helpers for the sequential shift-add multiplier.
package seq_mul_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  // Magnitude of a w-bit value (w in 2..32) held zero-extended in v; raw value when en=0.
  // The most negative input maps to 2^(w-1), which still fits unsigned in w bits.
  function automatic logic [31:0] abs_w(input logic [31:0] v, input logic en,
                                        input logic [5:0] w);
    logic [31:0] mask;
    logic [4:0]  msb;
    logic [31:0] r;
    mask = (w >= 6'd32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    msb  = w[4:0] - 5'd1;
    r    = v;
    if (en && v[msb]) r = (~v + 32'd1) & mask;
    return r;
  endfunction

endpackage

// File: rtl/add_n.sv
// Parametrised ripple-carry adder built from a chain of full-adder cells.
module add_n #(
  parameter int N = 8
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic [N-1:0] sum
);

  // Carry into each cell; the carry out of the top cell is not needed.
  logic [N-1:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < N; i++) begin : g_cell
    assign sum[i] = a[i] ^ b[i] ^ c[i];
    if (i < N - 1) begin : g_carry
      assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
  end

endmodule

// File: rtl/seq_mul_n.sv
// Sequential shift-add multiplier, one multiplier bit per clock, unsigned or signed
// per operation, with valid/ready handshakes on both sides.
module seq_mul_n
  import seq_mul_pkg::*;
#(
  parameter  int WIDTH = 8,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               signed_mode,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] p,
  output logic               busy
);

  localparam int PW = 2 * WIDTH;

  // Handshake: a transfer happens on a rising edge where valid and ready are both high.
  // in_ready is high only in IDLE; out_valid is high only in DONE, and p is stable there.

  state_t           state_q, state_d;
  logic [WIDTH-1:0] mcand_q, mplier_q;
  logic [WIDTH-1:0] mag_a, mag_b;
  logic [PW-1:0]    acc_q, p_q;
  logic [PW-1:0]    addend, acc_sum, acc_inv, acc_neg, result;
  logic [CNT_W-1:0] cnt_q;
  logic             neg_q;
  logic             last_step;

  assign mag_a = WIDTH'(abs_w(32'(a), signed_mode, 6'(WIDTH)));
  assign mag_b = WIDTH'(abs_w(32'(b), signed_mode, 6'(WIDTH)));

  assign addend    = mplier_q[0] ? ({{WIDTH{1'b0}}, mcand_q} << cnt_q) : '0;
  assign last_step = (cnt_q == CNT_W'(WIDTH - 1));

  add_n #(.N(PW)) u_acc_add (
    .a   (acc_q),
    .b   (addend),
    .cin (1'b0),
    .sum (acc_sum)
  );

  // Two's-complement negation as invert-plus-one.
  assign acc_inv = ~acc_sum;

  add_n #(.N(PW)) u_neg_add (
    .a   (acc_inv),
    .b   ({PW{1'b0}}),
    .cin (1'b1),
    .sum (acc_neg)
  );

  // A zero magnitude never picks the negated path, so the result is never -0.
  assign result = (neg_q && (acc_sum != '0)) ? acc_neg : acc_sum;

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_d = BUSY;
      end
      BUSY: begin
        busy = 1'b1;
        if (last_step) state_d = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      neg_q    <= 1'b0;
      p_q      <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            mcand_q  <= mag_a;
            mplier_q <= mag_b;
            neg_q    <= signed_mode & (a[WIDTH-1] ^ b[WIDTH-1]);
            acc_q    <= '0;
            cnt_q    <= '0;
          end
        end
        BUSY: begin
          acc_q    <= acc_sum;
          mplier_q <= mplier_q >> 1;
          cnt_q    <= cnt_q + CNT_W'(1);
          if (last_step) p_q <= result;
        end
        default: ;
      endcase
    end
  end

  assign p = p_q;

endmodule

// File: tb/tb_seq_mul_n.sv
// Directed bench for seq_mul_n at WIDTH=4 and WIDTH=8, plus a short reference-model sweep.
module tb_seq_mul_n;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic       iv4, ir4, sm4, ov4, or4, busy4;
  logic [3:0] a4, b4;
  logic [7:0] p4;

  logic        iv8, ir8, sm8, ov8, or8, busy8;
  logic [7:0]  a8, b8;
  logic [15:0] p8;

  seq_mul_n #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(iv4), .in_ready(ir4), .a(a4), .b(b4),
    .signed_mode(sm4), .out_valid(ov4), .out_ready(or4), .p(p4), .busy(busy4)
  );

  seq_mul_n #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8), .a(a8), .b(b8),
    .signed_mode(sm8), .out_valid(ov8), .out_ready(or8), .p(p8), .busy(busy8)
  );

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  task automatic accept4(input logic [3:0] a, input logic [3:0] b, input logic s,
                         output logic [7:0] pr, output int lat);
    @(negedge clk);
    a4 = a; b4 = b; sm4 = s; iv4 = 1'b1;
    @(posedge clk); #1;
    iv4 = 1'b0; a4 = 4'($urandom); b4 = 4'($urandom); sm4 = ~s;
    lat = 0;
    while (!ov4 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    pr = p4;
  endtask

  task automatic release4();
    or4 = 1'b1;
    @(posedge clk); #1;
    or4 = 1'b0;
  endtask

  task automatic accept8(input logic [7:0] a, input logic [7:0] b, input logic s,
                         output logic [15:0] pr, output int lat);
    @(negedge clk);
    a8 = a; b8 = b; sm8 = s; iv8 = 1'b1;
    @(posedge clk); #1;
    iv8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom); sm8 = ~s;
    lat = 0;
    while (!ov8 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    pr = p8;
  endtask

  task automatic release8();
    or8 = 1'b1;
    @(posedge clk); #1;
    or8 = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (ir4 !== 1'b1) begin errors++; $display("FAIL reset_in_ready4: got %b want 1", ir4); end
    checks++; if (ov4 !== 1'b0) begin errors++; $display("FAIL reset_out_valid4: got %b want 0", ov4); end
    checks++; if (busy4 !== 1'b0) begin errors++; $display("FAIL reset_busy4: got %b want 0", busy4); end
    checks++; if (p4 !== 8'h00) begin errors++; $display("FAIL reset_p4: got %h want 00", p4); end
    checks++; if (ir8 !== 1'b1) begin errors++; $display("FAIL reset_in_ready8: got %b want 1", ir8); end
    checks++; if (ov8 !== 1'b0) begin errors++; $display("FAIL reset_out_valid8: got %b want 0", ov8); end
    checks++; if (busy8 !== 1'b0) begin errors++; $display("FAIL reset_busy8: got %b want 0", busy8); end
    checks++; if (p8 !== 16'h0000) begin errors++; $display("FAIL reset_p8: got %h want 0000", p8); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_width4();
    logic [3:0] va[6] = '{4'hF, 4'h8, 4'h8, 4'hF, 4'h7, 4'h9};
    logic [3:0] vb[6] = '{4'hF, 4'h8, 4'h7, 4'hF, 4'hF, 4'h6};
    logic       vs[6] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [7:0] ve[6] = '{8'hE1, 8'h40, 8'hC8, 8'h01, 8'hF9, 8'h36};
    logic [7:0] pr;
    int         lat;
    for (int i = 0; i < 6; i++) begin
      accept4(va[i], vb[i], vs[i], pr, lat);
      checks++;
      if (lat !== 4) begin errors++; $display("FAIL w4_latency[%0d]: got %0d want 4", i, lat); end
      checks++;
      if (pr !== ve[i]) begin errors++; $display("FAIL w4_product[%0d]: got %h want %h", i, pr, ve[i]); end
      release4();
      checks++;
      if (ov4 !== 1'b0 || ir4 !== 1'b1) begin
        errors++; $display("FAIL w4_return_idle[%0d]: out_valid=%b in_ready=%b want 0/1", i, ov4, ir4);
      end
    end
  endtask

  task automatic test_corners8();
    logic [7:0]  va[5] = '{8'd255, 8'h80, 8'h7F, 8'hFF, 8'h80};
    logic [7:0]  vb[5] = '{8'd255, 8'h80, 8'h80, 8'h01, 8'h80};
    logic        vs[5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [15:0] ve[5] = '{16'hFE01, 16'h4000, 16'hC080, 16'hFFFF, 16'h4000};
    logic [15:0] pr;
    int          lat;
    for (int i = 0; i < 5; i++) begin
      accept8(va[i], vb[i], vs[i], pr, lat);
      checks++;
      if (lat !== 8) begin errors++; $display("FAIL w8_latency[%0d]: got %0d want 8", i, lat); end
      checks++;
      if (pr !== ve[i]) begin errors++; $display("FAIL w8_product[%0d]: got %h want %h", i, pr, ve[i]); end
      release8();
    end
  endtask

  task automatic test_backpressure();
    logic [15:0] pr;
    int          lat;
    int          bad;
    accept8(8'd200, 8'd3, 1'b0, pr, lat);
    checks++;
    if (lat !== 8) begin errors++; $display("FAIL bp_latency: got %0d want 8", lat); end
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      if (p8 !== 16'd600 || ov8 !== 1'b1 || ir8 !== 1'b0 || busy8 !== 1'b1) bad++;
      @(posedge clk); #1;
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL bp_hold: %0d bad stall cycles want 0 (p=%0d)", bad, p8); end
    release8();
    checks++;
    if (ov8 !== 1'b0 || ir8 !== 1'b1) begin
      errors++; $display("FAIL bp_release: out_valid=%b in_ready=%b want 0/1", ov8, ir8);
    end
    checks++;
    if (p8 !== 16'd600) begin errors++; $display("FAIL bp_p_kept: got %0d want 600", p8); end
  endtask

  task automatic test_reset_mid_busy();
    int seen;
    @(negedge clk);
    a8 = 8'd5; b8 = 8'd5; sm8 = 1'b0; iv8 = 1'b1;
    @(posedge clk); #1;
    iv8 = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++;
    if (ir8 !== 1'b1 || ov8 !== 1'b0 || busy8 !== 1'b0) begin
      errors++; $display("FAIL rst_mid_flags: in_ready=%b out_valid=%b busy=%b want 1/0/0", ir8, ov8, busy8);
    end
    checks++;
    if (p8 !== 16'h0000) begin errors++; $display("FAIL rst_mid_p: got %h want 0000", p8); end
    seen = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (ov8) seen++;
    end
    checks++;
    if (seen != 0) begin errors++; $display("FAIL rst_mid_no_result: got %0d valid cycles want 0", seen); end
  endtask

  task automatic test_zero_ignore();
    int seen;
    int lat;
    @(negedge clk);
    a8 = 8'h00; b8 = 8'h80; sm8 = 1'b1; iv8 = 1'b1;
    @(posedge clk); #1;
    iv8 = 1'b0;
    lat = 0;
    seen = 0;
    while (!ov8 && lat < 40) begin
      if (lat == 3) begin
        a8 = 8'd9; b8 = 8'd9; iv8 = 1'b1;
      end else begin
        iv8 = 1'b0;
      end
      @(posedge clk); #1;
      lat++;
    end
    iv8 = 1'b0;
    checks++;
    if (lat !== 8) begin errors++; $display("FAIL zero_latency: got %0d want 8", lat); end
    checks++;
    if (p8 !== 16'h0000) begin errors++; $display("FAIL zero_product: got %h want 0000", p8); end
    release8();
    repeat (20) begin
      @(posedge clk); #1;
      if (ov8) seen++;
    end
    checks++;
    if (seen != 0) begin errors++; $display("FAIL ignore_busy_pulse: got %0d extra valid cycles want 0", seen); end
  endtask

  task automatic test_back_to_back();
    logic [7:0]  ra, rb;
    logic        rs;
    logic [15:0] pr, exp_p;
    int          lat, sa, sb;
    int          bad_p, bad_lat;
    bad_p = 0;
    bad_lat = 0;
    for (int n = 0; n < 300; n++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      rs = 1'($urandom_range(1, 0));
      if (rs) begin
        sa = int'($signed(ra));
        sb = int'($signed(rb));
      end else begin
        sa = int'(ra);
        sb = int'(rb);
      end
      exp_p = 16'(sa * sb);
      accept8(ra, rb, rs, pr, lat);
      repeat ($urandom_range(3, 0)) @(posedge clk);
      #1;
      if (p8 !== pr) bad_p++;
      if (pr !== exp_p) begin
        bad_p++;
        if (bad_p < 5) $display("FAIL sweep_product: a=%h b=%h s=%b got %h want %h", ra, rb, rs, pr, exp_p);
      end
      if (lat != 8) bad_lat++;
      release8();
    end
    checks++;
    if (bad_p != 0) begin errors++; $display("FAIL sweep_products: %0d bad want 0", bad_p); end
    checks++;
    if (bad_lat != 0) begin errors++; $display("FAIL sweep_latency: %0d bad want 0", bad_lat); end
  endtask

  initial begin
    rst = 1'b1;
    iv4 = 1'b0; or4 = 1'b0; a4 = '0; b4 = '0; sm4 = 1'b0;
    iv8 = 1'b0; or8 = 1'b0; a8 = '0; b8 = '0; sm8 = 1'b0;
    test_reset();
    test_width4();
    test_corners8();
    test_backpressure();
    test_reset_mid_busy();
    test_zero_ignore();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
